// File: rtl/snake_head_stepper_if.sv
// snake_head_stepper_if: counter/button inputs and head, tail and collision outputs of the head stepper
interface snake_head_stepper_if #(parameter int XW = 6, parameter int YW = 5);
  logic [9:0]    count;
  logic [9:0]    max;
  logic          btn_up;
  logic          btn_down;
  logic          btn_left;
  logic          btn_right;
  logic          grow;
  logic          step;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          tail_valid;
  logic [XW-1:0] tail_x;
  logic [YW-1:0] tail_y;
  logic [4:0]    length;
  logic          self_hit;
  modport master (
    output count, max, btn_up, btn_down, btn_left, btn_right, grow,
    input  step, head_x, head_y, tail_valid, tail_x, tail_y, length, self_hit
  );
  modport slave (
    input  count, max, btn_up, btn_down, btn_left, btn_right, grow,
    output step, head_x, head_y, tail_valid, tail_x, tail_y, length, self_hit
  );
endinterface

// File: rtl/snake_head_stepper.sv
// snake_head_stepper: steps the snake head once per counter arrival at max, tracks the body ring and self-collision
module snake_head_stepper #(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int XW      = 6,
  parameter int YW      = 5,
  parameter int LEN_MAX = 16,
  parameter int START_X = 20,
  parameter int START_Y = 15
) (
  input logic clock,
  input logic reset,
  snake_head_stepper_if.slave bus
);
  localparam int PW = $clog2(LEN_MAX);
  typedef enum logic [1:0] {RIGHT = 2'b00, DOWN = 2'b01, LEFT = 2'b10, UP = 2'b11} dir_t;
  dir_t          dir, pend, req, pend_nxt;
  logic [9:0]    prev_count;
  logic          grow_pend, tick, act, grow_eff, do_grow, hit, any_btn;
  logic [PW-1:0] head_ptr, next_ptr, tail_ptr;
  logic [XW-1:0] body_x [LEN_MAX];
  logic [YW-1:0] body_y [LEN_MAX];
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  always_comb begin
    tick = bus.count == bus.max && prev_count != bus.max;
    act = tick && !bus.self_hit;
    any_btn = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    req = bus.btn_up ? UP : bus.btn_down ? DOWN : bus.btn_left ? LEFT : RIGHT;
    // reversal is judged against the committed direction, not the pending one
    pend_nxt = (any_btn && req != dir_t'(dir ^ 2'b10)) ? req : pend;
    grow_eff = grow_pend || bus.grow;
    do_grow = grow_eff && bus.length < 5'(LEN_MAX);
    nx = pend_nxt == RIGHT ? (bus.head_x == XW'(GRID_W - 1) ? '0 : bus.head_x + 1'b1) :
         pend_nxt == LEFT  ? (bus.head_x == '0 ? XW'(GRID_W - 1) : bus.head_x - 1'b1) : bus.head_x;
    ny = pend_nxt == DOWN  ? (bus.head_y == YW'(GRID_H - 1) ? '0 : bus.head_y + 1'b1) :
         pend_nxt == UP    ? (bus.head_y == '0 ? YW'(GRID_H - 1) : bus.head_y - 1'b1) : bus.head_y;
    next_ptr = head_ptr == PW'(LEN_MAX - 1) ? '0 : head_ptr + 1'b1;
    tail_ptr = PW'((int'(head_ptr) + LEN_MAX + 1 - int'(bus.length)) % LEN_MAX);
    hit = 1'b0;
    // a slot is occupied when it lies within length of the head; the tail slot is free if it drops this step
    for (int i = 0; i < LEN_MAX; i++)
      if ((int'(head_ptr) - i + LEN_MAX) % LEN_MAX < int'(bus.length) &&
          !(PW'(i) == tail_ptr && !do_grow) && body_x[i] == nx && body_y[i] == ny)
        hit = 1'b1;
  end
  always_ff @(posedge clock) begin
    prev_count <= reset ? '0 : bus.count;
    if (reset) begin
      dir            <= RIGHT;
      pend           <= RIGHT;
      grow_pend      <= 1'b0;
      head_ptr       <= '0;
      body_x[0]      <= XW'(START_X);
      body_y[0]      <= YW'(START_Y);
      bus.head_x     <= XW'(START_X);
      bus.head_y     <= YW'(START_Y);
      bus.length     <= 5'd1;
      bus.step       <= 1'b0;
      bus.tail_valid <= 1'b0;
      bus.tail_x     <= '0;
      bus.tail_y     <= '0;
      bus.self_hit   <= 1'b0;
    end else begin
      bus.step       <= act;
      bus.tail_valid <= 1'b0;
      pend           <= pend_nxt;
      grow_pend      <= act ? 1'b0 : grow_eff;
      if (act) dir <= pend_nxt;
      if (act && hit) bus.self_hit <= 1'b1;
      if (act && !hit) begin
        head_ptr         <= next_ptr;
        body_x[next_ptr] <= nx;
        body_y[next_ptr] <= ny;
        bus.head_x       <= nx;
        bus.head_y       <= ny;
        if (do_grow) bus.length <= bus.length + 1'b1;
        else begin
          bus.tail_valid <= 1'b1;
          bus.tail_x     <= body_x[tail_ptr];
          bus.tail_y     <= body_y[tail_ptr];
        end
      end
    end
  end
endmodule
